// File: rtl/program_loader_pkg.sv
// Shared CPU package: loader state encoding, word/address geometry and the
// RAM write payload type.
package program_loader_pkg;

   localparam int unsigned WORD_W  = 9;
   localparam int unsigned ADDR_W  = 3;
   localparam int unsigned WORDS   = 8;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_LO    = 3'd1;
   localparam logic [STATE_W-1:0] ST_HI    = 3'd2;
   localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
   localparam logic [STATE_W-1:0] ST_CHK   = 3'd4;
   localparam logic [STATE_W-1:0] ST_RUN   = 3'd5;
   localparam logic [STATE_W-1:0] ST_ERR   = 3'd6;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } ram_wr_t;

   // Bit 0 of the high byte becomes word bit 8; bits 7:1 are discarded.
   function automatic logic [WORD_W-1:0] merge_hi(input logic [WORD_W-1:0] word,
                                                 input logic [BYTE_W-1:0] hi_byte);
      return {hi_byte[0], word[BYTE_W-1:0]};
   endfunction

endpackage

// File: rtl/program_loader.sv
// Streams 8 nine-bit words (low byte, high byte) into CPU RAM, verifies an XOR
// checksum byte, then releases the CPU via pc_enable or flags error.
module program_loader
   import program_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic [WORD_W-1:0] ram_wr_data,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic              ram_wr_en,
   output logic              pc_enable,
   output logic              busy,
   output logic              error
);

   logic [STATE_W-1:0] state_q, state_d;
   ram_wr_t            wr_q, wr_d;
   logic [BYTE_W-1:0]  csum_q, csum_d;
   logic               in_ready_q, in_ready_d;
   logic               wr_en_q, wr_en_d;
   logic               pc_enable_q, pc_enable_d;
   logic               busy_q, busy_d;
   logic               error_q, error_d;
   logic               xfer;

   // Next state plus registered outputs, all derived from the next state.
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      csum_d      = csum_q;
      in_ready_d  = 1'b0;
      wr_en_d     = 1'b0;
      pc_enable_d = 1'b0;
      busy_d      = 1'b0;
      error_d     = 1'b0;
      xfer        = in_valid & in_ready_q;

      case (state_q)
         ST_IDLE, ST_RUN, ST_ERR: begin
            if (start) begin
               state_d     = ST_LO;
               wr_d.addr   = '0;
               csum_d      = '0;
            end
         end
         ST_LO: begin
            if (xfer) begin
               wr_d.data = {wr_q.data[WORD_W-1], in_data};
               csum_d    = csum_q ^ in_data;
               state_d   = ST_HI;
            end
         end
         ST_HI: begin
            if (xfer) begin
               wr_d.data = merge_hi(wr_q.data, in_data);
               csum_d    = csum_q ^ in_data;
               state_d   = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wr_d.addr = wr_q.addr + ADDR_W'(1);
            state_d   = (wr_q.addr == ADDR_W'(WORDS - 1)) ? ST_CHK : ST_LO;
         end
         ST_CHK: begin
            if (xfer) begin
               state_d = (in_data == csum_q) ? ST_RUN : ST_ERR;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d  = (state_d == ST_LO) || (state_d == ST_HI) || (state_d == ST_CHK);
      busy_d      = in_ready_d || (state_d == ST_WRITE);
      wr_en_d     = (state_d == ST_WRITE);
      pc_enable_d = (state_d == ST_RUN);
      error_d     = (state_d == ST_ERR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         wr_q        <= '0;
         csum_q      <= '0;
         in_ready_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         pc_enable_q <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         csum_q      <= csum_d;
         in_ready_q  <= in_ready_d;
         wr_en_q     <= wr_en_d;
         pc_enable_q <= pc_enable_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign ram_wr_data = wr_q.data;
   assign ram_wr_addr = wr_q.addr;
   assign ram_wr_en   = wr_en_q;
   assign pc_enable   = pc_enable_q;
   assign busy        = busy_q;
   assign error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a driver pushes expected RAM
// writes, a monitor pops and compares them on every ram_wr_en pulse.
module tb_program_loader;
   import program_loader_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic [8:0] ram_wr_data;
   logic [2:0] ram_wr_addr;
   logic       ram_wr_en;
   logic       pc_enable;
   logic       busy;
   logic       error;

   program_loader dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .ram_wr_data(ram_wr_data),
      .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en), .pc_enable(pc_enable),
      .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [11:0] exp_q[$];
   logic [7:0]  lo_b[8];
   logic [7:0]  hi_b[8];
   logic [8:0]  nominal[8] = '{9'h1A5, 9'h003, 9'h100, 9'h0FF, 9'h000, 9'h155, 9'h0AA, 9'h1FF};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write pulse must match the oldest expected write.
   initial begin
      logic [11:0] e;
      forever begin
         @(negedge clk);
         if (ram_wr_en === 1'b1) begin
            check("in_ready_low_in_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: addr=%0d data=0x%0h with no expected write", ram_wr_addr, ram_wr_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(ram_wr_addr), 32'(e[11:9]));
               check("wr_data", 32'(ram_wr_data), 32'(e[8:0]));
            end
         end
      end
   end

   function automatic logic [7:0] model_csum();
      logic [7:0] c = 8'h00;
      for (int i = 0; i < 8; i++) c = c ^ lo_b[i] ^ hi_b[i];
      return c;
   endfunction

   function automatic int pick_gap(input int mode);
      if (mode == 0) return 0;
      if (mode == 1) return 1;
      return int'($urandom_range(0, 3));
   endfunction

   task automatic set_nominal();
      for (int i = 0; i < 8; i++) begin
         lo_b[i] = nominal[i][7:0];
         hi_b[i] = {7'b0, nominal[i][8]};
      end
   endtask

   task automatic set_random();
      for (int i = 0; i < 8; i++) begin
         lo_b[i] = 8'($urandom);
         hi_b[i] = 8'($urandom);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got = 1'b0;
      in_valid = 1'b0;
      repeat (gap) begin
         in_data = 8'($urandom);
         @(posedge clk); #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            got = 1'b1;
         end
      end
      in_valid = 1'b0;
      check("byte_accepted", 32'(got), 32'd1);
   endtask

   // One load of nwords words; with all 8 words the checksum byte
   // (model checksum XOR bad_xor) is sent and the final state checked.
   task automatic do_load(input bit do_start, input logic [7:0] bad_xor, input int mode,
                          input bit start_mid, input int nwords);
      logic [7:0] cs = model_csum();
      bit bad = (bad_xor != 8'h00);
      if (do_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < nwords; i++) exp_q.push_back({3'(i), hi_b[i][0], lo_b[i]});
      for (int i = 0; i < nwords; i++) begin
         if (start_mid && i == 2) start = 1'b1;
         send_byte(lo_b[i], pick_gap(mode));
         send_byte(hi_b[i], pick_gap(mode));
         start = 1'b0;
      end
      if (nwords == 8) begin
         send_byte(cs ^ bad_xor, pick_gap(mode));
         check("pc_enable_after_chk", 32'(pc_enable), 32'(!bad));
         check("error_after_chk", 32'(error), 32'(bad));
         check("busy_after_chk", 32'(busy), 32'd0);
         check("in_ready_after_chk", 32'(in_ready), 32'd0);
         check("writes_outstanding", 32'(exp_q.size()), 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_wr_en", 32'(ram_wr_en), 32'd0);
      check("rst_pc_enable", 32'(pc_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_addr", 32'(ram_wr_addr), 32'd0);
      check("rst_data", 32'(ram_wr_data), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;

      // Nominal load
      set_nominal();
      do_load(1'b1, 8'h00, 0, 1'b0, 8);

      // Restart from RUN, then the same stream with a 0x00 checksum byte
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("restart_pc_enable", 32'(pc_enable), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_in_ready", 32'(in_ready), 32'd1);
      do_load(1'b0, model_csum(), 0, 1'b0, 8);

      // HI-byte masking, restarted from ERR
      set_random();
      hi_b[0] = 8'hFE;
      hi_b[1] = 8'h01;
      do_load(1'b1, 8'h00, 2, 1'b0, 8);

      // Backpressure: one idle cycle before every byte
      set_nominal();
      do_load(1'b1, 8'h00, 1, 1'b0, 8);

      // Reset after word 3 is written
      set_random();
      do_load(1'b1, 8'h00, 2, 1'b0, 4);
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
      check("midload_writes_seen", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_wr_en", 32'(ram_wr_en), 32'd0);
      check("mid_rst_addr", 32'(ram_wr_addr), 32'd0);
      check("mid_rst_data", 32'(ram_wr_data), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_pc_enable", 32'(pc_enable), 32'd0);
      @(posedge clk); #1;
      set_random();
      do_load(1'b1, 8'h00, 2, 1'b0, 8);

      // Random loads, some with bad checksums and a stray start mid-load
      for (int k = 0; k < 4; k++) begin
         set_random();
         do_load(1'b1, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 2, (k % 2) == 1, 8);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
